// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake bundle for the bit-serial adder controller.
// The sub signal is present only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic [2:0]       bit_sel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
      output sub,
`endif
      input  bit_sel, busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
      input  sub,
`endif
      output bit_sel, busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first, start/done handshake.
// Define SERIAL_ADD_SUB_EN to add a latched sub input that computes a-b instead of a+b+cin.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   serial_adder_ctrl_if.slave io_bus
);
   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_sum;
   logic [CntW-1:0]  r_count;
   logic             r_carry;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic [2:0]       r_bit_sel;

   logic [WIDTH-1:0] w_b_load;
   logic             w_cin_load;
   logic             w_fa_sum;
   logic             w_fa_carry;
   logic             w_last;

   // Subtract stores ~b so the shift register already holds the bit that enters bit_sel.
`ifdef SERIAL_ADD_SUB_EN
   assign w_b_load   = io_bus.sub ? ~io_bus.b : io_bus.b;
   assign w_cin_load = io_bus.sub | io_bus.cin;
`else
   assign w_b_load   = io_bus.b;
   assign w_cin_load = io_bus.cin;
`endif

   assign w_fa_sum   = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
   assign w_fa_carry = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
   assign w_last     = (r_count == LastCnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_a_sr    <= '0;
         r_b_sr    <= '0;
         r_sum     <= '0;
         r_count   <= '0;
         r_carry   <= 1'b0;
         r_cout    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bit_sel <= 3'b000;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io_bus.start) begin
                  r_a_sr    <= io_bus.a;
                  r_b_sr    <= w_b_load;
                  r_carry   <= w_cin_load;
                  r_count   <= '0;
                  r_sum     <= '0;
                  r_busy    <= 1'b1;
                  r_bit_sel <= {io_bus.a[0], w_b_load[0], w_cin_load};
                  r_state   <= StRun;
               end
            end
            StRun: begin
               r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
               r_carry <= w_fa_carry;
               r_count <= r_count + CntW'(1);
               // bit_sel is registered, so it is loaded with the next bit's operands.
               if (w_last) begin
                  r_cout    <= w_fa_carry;
                  r_done    <= 1'b1;
                  r_bit_sel <= 3'b000;
                  r_state   <= StDone;
               end else begin
                  r_bit_sel <= {r_a_sr[1], r_b_sr[1], w_fa_carry};
               end
            end
            StDone: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign io_bus.bit_sel = r_bit_sel;
   assign io_bus.busy    = r_busy;
   assign io_bus.done    = r_done;
   assign io_bus.sum     = r_sum;
   assign io_bus.cout    = r_cout;
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller that drives a 1-bit full-adder stage one bit per clock, LSB first. It latches two operands and a carry-in, then presents {a_bit, b_bit, carry} as a 3-bit select vector to the full-adder stage. Each cycle it registers the returned sum bit into a result shift register and the carry into a carry flip-flop. It sits directly upstream of the full-adder stage and wraps it into a multi-bit adder with a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; latched on accepted start
b  input  WIDTH  operand B; latched on accepted start
cin  input  1  carry-in; latched on accepted start
bit_sel  output  3  select vector to the full-adder stage: {a_bit, b_bit, carry}
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result; held until the next accepted start
cout  output  1  registered final carry; held until the next accepted start

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, operand shift regs=0, carry=0, count=0, sum=0, cout=0, busy=0, done=0, bit_sel=0. Reset mid-operation aborts the add. No partial result is kept and done is not asserted.
- Full-adder stage: an internal combinational 1-bit stage. fa_sum = a_bit^b_bit^carry. fa_carry = majority(a_bit, b_bit, carry).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - bit_sel=0.
  - If start=1 at an edge: a_sr<=a, b_sr<=b, carry<=cin, count<=0, sum<=0, state<=RUN.
  - start=0: remain in IDLE, all registers hold.
- RUN: bit_sel={a_sr[0], b_sr[0], carry}. At each edge:
  - sum <= {fa_sum, sum[WIDTH-1:1]}
  - carry <= fa_carry
  - a_sr and b_sr shift right, zero fill
  - count <= count+1
  - When count==WIDTH-1 at the edge: cout<=fa_carry, state<=DONE.
- DONE: done=1 for exactly one cycle, bit_sel=0, then state<=IDLE unconditionally.
- Latency: call the edge that accepts start edge 1.
  - Edges 2..WIDTH+1 process bits 0..WIDTH-1.
  - done is high for the cycle following edge WIDTH+1.
  - Back in IDLE after edge WIDTH+2.
  - Back-to-back throughput: one add per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored; no queuing.
- a, b and cin may change freely after acceptance without affecting the result.
- sum and cout read during RUN show in-progress values and are undefined to consumers. They are valid from the done cycle until the next accepted start.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via cout.
- count is $clog2(WIDTH)+1 bits wide so it never wraps in RUN.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined: adds input port sub (1 bit), latched on accepted start.
  - sub=1: the b bit is inverted before entering bit_sel and the carry is initialised to 1; cin is ignored.
  - Result is a-b mod 2^WIDTH; cout=1 means no borrow.
  - sub=0: identical to an add.
- Undefined: the sub port is absent and the block is add-only.
- Timing is identical either way.

Test Plan:
1. WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulse -> done high for exactly the cycle after edge 9; sum=0x96, cout=0; busy high during the 9 cycles after edge 1.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. bit_sel on the first RUN cycle is 3'b111.
3. Accept a=0x10, b=0x20, cin=0; drive start=1 continuously plus new a=0xAA during RUN -> result still 0x30, cout=0; next add is accepted only on the edge after DONE returns to IDLE.
4. Assert rst for one cycle at edge 5 of an add of 0x7F+0x01 -> state IDLE, sum=0, cout=0, busy=0, no done pulse. A following add of 0x01+0x02 yields 0x03.
5. SERIAL_ADD_SUB_EN defined, a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0. a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
6. WIDTH=4 build, a=0x9, b=0x8, cin=1 -> sum=0x2, cout=1, done after edge 5.
